// File: rtl/n101_tl_pkg.sv
// Shared TileLink-UL D-channel definitions for the n101 peripheral width adapter.
package n101_tl_pkg;

  localparam logic [2:0] TL_D_ACCESSACK     = 3'd0;
  localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;

  localparam int TL_OPCODE_W = 3;
  localparam int TL_PARAM_W  = 2;
  localparam int TL_SIZE_W   = 3;
  localparam int TL_SOURCE_W = 2;

  localparam int TL_OUT_BYTES = 4;
  localparam int TL_CNT_W     = $clog2(TL_OUT_BYTES);

  typedef struct packed {
    logic [TL_OPCODE_W-1:0] opcode;
    logic [TL_PARAM_W-1:0]  param;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
  } hdr_t;

  // Narrow beats per wide beat minus one: min(2^size, OUT_BYTES) - 1.
  function automatic logic [TL_CNT_W-1:0] beats_m1(input logic [TL_SIZE_W-1:0] size);
    logic [TL_CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < TL_CNT_W; i++) begin
      if (int'(size) > i) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic has_data(input logic [TL_OPCODE_W-1:0] opcode);
    return opcode == TL_D_ACCESSACKDATA;
  endfunction

endpackage

// File: rtl/n101_tl_d_lane_pack.sv
// Replicates the collected narrow lanes across the wide word according to size.
// Combinational, no backpressure.
module n101_tl_d_lane_pack
  import n101_tl_pkg::*;
#(
  parameter int OUT_BYTES = TL_OUT_BYTES,
  parameter int LANE_W    = 8,
  parameter int CNT_W     = $clog2(OUT_BYTES)
) (
  input  logic [TL_SIZE_W-1:0]               size,
  input  logic [OUT_BYTES-1:0][LANE_W-1:0]   lanes,
  output logic [OUT_BYTES*LANE_W-1:0]        data
);

  logic [CNT_W-1:0] mask;

  always_comb begin
    mask = beats_m1(size);
    data = '0;
    // Output lane i repeats collected lane (i mod N); N is a power of two.
    for (int i = 0; i < OUT_BYTES; i++) begin
      data[i*LANE_W +: LANE_W] = lanes[CNT_W'(i) & mask];
    end
  end

endmodule

// File: rtl/n101_tl_d_gather.sv
// Gathers 1/2/4 narrow TL-UL D beats into one wide D beat; 1-cycle registered output.
// Non-last beats always accepted; the last beat waits for the output slot to free.
module n101_tl_d_gather
  import n101_tl_pkg::*;
#(
  parameter int IN_BYTES  = 1,
  parameter int OUT_BYTES = TL_OUT_BYTES,
  parameter int CNT_W     = $clog2(OUT_BYTES)
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        io_enq_ready,
  input  logic                        io_enq_valid,
  input  logic [TL_OPCODE_W-1:0]      io_enq_bits_opcode,
  input  logic [TL_PARAM_W-1:0]       io_enq_bits_param,
  input  logic [TL_SIZE_W-1:0]        io_enq_bits_size,
  input  logic [TL_SOURCE_W-1:0]      io_enq_bits_source,
  input  logic                        io_enq_bits_error,
  input  logic [8*IN_BYTES-1:0]       io_enq_bits_data,
  input  logic                        io_deq_ready,
  output logic                        io_deq_valid,
  output logic [TL_OPCODE_W-1:0]      io_deq_bits_opcode,
  output logic [TL_PARAM_W-1:0]       io_deq_bits_param,
  output logic [TL_SIZE_W-1:0]        io_deq_bits_size,
  output logic [TL_SOURCE_W-1:0]      io_deq_bits_source,
  output logic                        io_deq_bits_error,
  output logic [8*IN_BYTES*OUT_BYTES-1:0] io_deq_bits_data,
  output logic                        io_busy
);

  localparam int LANE_W = 8 * IN_BYTES;

  logic [CNT_W-1:0]                 count_q;
  logic [CNT_W-1:0]                 n_m1_q;
  hdr_t                             hdr_q;
  logic                             err_q;
  logic [OUT_BYTES-1:0][LANE_W-1:0] lanes_q;

  logic                             deq_valid_q;
  hdr_t                             deq_hdr_q;
  logic                             deq_err_q;
  logic [OUT_BYTES*LANE_W-1:0]      deq_data_q;

  hdr_t                             enq_hdr;
  hdr_t                             grp_hdr;
  logic                             first;
  logic                             last;
  logic                             fire;
  logic [CNT_W-1:0]                 n_m1_cur;
  logic [OUT_BYTES-1:0][LANE_W-1:0] lanes_next;
  logic [OUT_BYTES*LANE_W-1:0]      packed_data;

  always_comb begin
    enq_hdr = '{opcode: io_enq_bits_opcode, param: io_enq_bits_param,
                size: io_enq_bits_size, source: io_enq_bits_source};
    first    = (count_q == '0);
    // Group length and header come from the first beat; later headers are ignored.
    n_m1_cur = first ? beats_m1(io_enq_bits_size) : n_m1_q;
    grp_hdr  = first ? enq_hdr : hdr_q;
    last     = (count_q == n_m1_cur);
    io_enq_ready = last ? (!deq_valid_q || io_deq_ready) : 1'b1;
    fire     = io_enq_valid && io_enq_ready;
    lanes_next = lanes_q;
    lanes_next[count_q] = io_enq_bits_data;
  end

  n101_tl_d_lane_pack #(
    .OUT_BYTES (OUT_BYTES),
    .LANE_W    (LANE_W),
    .CNT_W     (CNT_W)
  ) u_lane_pack (
    .size  (grp_hdr.size),
    .lanes (lanes_next),
    .data  (packed_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      n_m1_q      <= '0;
      hdr_q       <= '0;
      err_q       <= 1'b0;
      lanes_q     <= '0;
      deq_valid_q <= 1'b0;
      deq_hdr_q   <= '0;
      deq_err_q   <= 1'b0;
      deq_data_q  <= '0;
    end else begin
      if (fire && !last) begin
        lanes_q <= lanes_next;
        err_q   <= err_q | io_enq_bits_error;
        count_q <= count_q + 1'b1;
        if (first) begin
          hdr_q  <= enq_hdr;
          n_m1_q <= n_m1_cur;
        end
      end
      if (fire && last) begin
        deq_hdr_q   <= grp_hdr;
        deq_err_q   <= err_q | io_enq_bits_error;
        deq_data_q  <= has_data(grp_hdr.opcode) ? packed_data : '0;
        deq_valid_q <= 1'b1;
        count_q     <= '0;
        err_q       <= 1'b0;
      end else if (io_deq_ready) begin
        deq_valid_q <= 1'b0;
      end
    end
  end

  assign io_deq_valid       = deq_valid_q;
  assign io_deq_bits_opcode = deq_hdr_q.opcode;
  assign io_deq_bits_param  = deq_hdr_q.param;
  assign io_deq_bits_size   = deq_hdr_q.size;
  assign io_deq_bits_source = deq_hdr_q.source;
  assign io_deq_bits_error  = deq_err_q;
  assign io_deq_bits_data   = deq_data_q;
  assign io_busy            = (count_q != '0);

endmodule

// File: doc/n101_tl_d_gather.md
Name: n101_tl_d_gather

Overview:
- TileLink-UL D-channel response gatherer for the n101 peripheral width adapter.
- It is the return-path counterpart of the A-channel beat repeater: the repeater replays one wide A request as several 8-bit narrow beats, and this block collects the resulting narrow D beats into one 32-bit D beat for the core-side bus.
- It sits between the 8-bit peripheral crossbar D output and the 32-bit system bus D input.

Parameters:
- IN_BYTES, 1, narrow data width in bytes (fixed at 1 in this design).
- OUT_BYTES, 4, wide data width in bytes; must be a power of two and at least 2.
- CNT_W, 2, log2(OUT_BYTES); width of the beat counter.

Ports:
- clock  input  1  clock
- reset  input  1  asynchronous, active-high reset
- io_enq_ready  output  1  narrow D beat accepted
- io_enq_valid  input  1  narrow D beat present
- io_enq_bits_opcode  input  3  0 = AccessAck, 1 = AccessAckData
- io_enq_bits_param  input  2  reserved, forwarded
- io_enq_bits_size  input  3  log2 of the original request size in bytes
- io_enq_bits_source  input  2  request source ID
- io_enq_bits_error  input  1  beat error flag
- io_enq_bits_data  input  8  narrow read data
- io_deq_ready  input  1  wide side accepts the beat
- io_deq_valid  output  1  wide D beat present
- io_deq_bits_opcode  output  3  opcode of the first narrow beat of the group
- io_deq_bits_param  output  2  param of the first narrow beat
- io_deq_bits_size  output  3  size of the first narrow beat
- io_deq_bits_source  output  2  source of the first narrow beat
- io_deq_bits_error  output  1  OR of the error flags of all narrow beats in the group
- io_deq_bits_data  output  32  assembled wide data
- io_busy  output  1  a group is partially collected (count != 0)

Behaviour:
- Reset (asynchronous, active-high): count = 0; accumulator, header and error registers = 0; all output registers = 0; io_deq_valid = 0; io_busy = 0.
- Beats per group, N: 1 if size = 0; 2 if size = 1; 4 (= OUT_BYTES) if size >= 2.
  - N is computed from the size of the first beat of the group and held in a register for the rest of the group.
- Sizes above 2 (bursts) produce 2^size / 4 consecutive wide beats.
  - count wraps to 0 after each group of 4.
  - Each wide beat carries its own header, taken from its own first narrow beat.
- count (CNT_W bits) is the index of the next narrow beat within the current group.
- A narrow beat is the last of its group when count == N-1.
- Non-last beats:
  - io_enq_ready = 1 unconditionally, so accumulation proceeds even while the output is stalled.
  - On the handshake: store the data byte in lane[count], OR the error flag into the error register, count++.
  - When count == 0, also capture opcode, param, size, source and N.
- Last beat:
  - io_enq_ready = !io_deq_valid || io_deq_ready.
  - On the handshake, load the output registers: header, error OR including this beat, and assembled data. Then set io_deq_valid = 1, clear count, clear the error accumulator.
- Data assembly:
  - size 0: {b0,b0,b0,b0}.
  - size 1: {b1,b0,b1,b0}.
  - size >= 2: {b3,b2,b1,b0}, with b0 in bits [7:0].
- For opcode AccessAck, narrow acks are still counted to N; output data is 0.
- Latency: the last narrow handshake in cycle t gives io_deq_valid = 1 in cycle t+1 (one-stage registered output).
- io_deq_valid is cleared on io_deq_ready && io_deq_valid, unless a new last beat is accepted in the same cycle; in that case the output reloads and valid stays 1. This sustains full throughput with size = 0.
- io_deq_bits_* hold stable while io_deq_valid && !io_deq_ready.
- Header fields of narrow beats 1..N-1 are not compared; mismatches are ignored. The bench asserts in-order, same-source delivery.
- Reset mid-group discards the partial accumulation. No wide beat is emitted for the discarded narrow beats.

Decomposition:
- Shared package n101_tl_pkg holds:
  - D opcode constants TL_D_ACCESSACK = 3'd0 and TL_D_ACCESSACKDATA = 3'd1.
  - Field widths: opcode 3, param 2, size 3, source 2.
  - OUT_BYTES default.
- One natural sub-module: n101_tl_d_lane_pack, a combinational mapping of {size, b0..b3} to 32-bit replicated data.
- Counter, accumulator and output stage stay in the top module.

Test Plan:
- Reset, then size=2 AccessAckData source=1 with bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, deq_ready=1 → one deq beat the cycle after 0x44: data=0x44332211, size=2, source=1, error=0.
- size=0 read, byte 0xA5, deq_ready=1, eight back-to-back requests → a deq beat every cycle with data=0xA5A5A5A5; enq_ready stays 1 throughout.
- size=1 AccessAck (write) with two narrow acks, second ack error=1 → a single deq beat: opcode=0, data=0, error=1; no deq beat after the first ack.
- size=3 read with 8 bytes 0x01..0x08 and deq_ready=0 for 5 cycles after the first group:
  - First wide beat 0x04030201 holds stable through the stall.
  - Narrow beats 5–7 are accepted during the stall; enq_ready drops only on beat 8 until deq_ready.
  - Second wide beat = 0x08070605.
- Assert reset after 2 of 4 narrow beats of a size=2 read, then send a fresh size=2 group 0xDE, 0xAD, 0xBE, 0xEF → deq data=0xEFBEADDE; no stale bytes; io_busy=0 immediately after reset.
